timer_cnt: RTL and testbench

Timer counter that consumes the selected divided clock from the clock-select stage and turns it into a counting tick. It runs entirely in the `pclk` domain. `clk_in` is a level derived from `pclk`; it is sampled, and each rising edge becomes a one-cycle tick enable. The tick drives a loadable up/down counter with sticky overflow and underflow flags. The block sits between the clock-select stage and the APB register file, which owns `en`, `dir`, `load`, `tdr` and the flag clears.

---
 rtl/timer_cnt_pkg.sv | 11 +
 rtl/timer_cnt_if.sv | 30 +++
 rtl/timer_cnt_tick_gen.sv | 25 ++
 rtl/timer_cnt.sv | 75 +++++++
 tb/tb_timer_cnt.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/timer_cnt_pkg.sv
// Shared definitions for the timer counter and its tick generator.
package timer_pkg;

    localparam int TMR_WIDTH = 8;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef logic [TMR_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/timer_cnt_if.sv
// Control/status bundle between the clock-select/APB side and the timer counter.
interface timer_cnt_if
    import timer_pkg::*;
#(
    parameter int WIDTH = TMR_WIDTH
);
    logic             clk_in;
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] tdr;
    logic             ovf_clr;
    logic             udf_clr;
    logic [WIDTH-1:0] cnt;
    logic             ovf;
    logic             udf;
    logic             tick;

    // Register-file side: drives controls, observes count and flags.
    modport master (
        output clk_in, en, dir, load, tdr, ovf_clr, udf_clr,
        input  cnt, ovf, udf, tick
    );

    // Timer side: consumes controls, produces count and flags.
    modport slave (
        input  clk_in, en, dir, load, tdr, ovf_clr, udf_clr,
        output cnt, ovf, udf, tick
    );
endinterface

// File: rtl/timer_cnt_tick_gen.sv
// Two-flop sampler plus rising-edge detector for a pclk-derived divided clock.
// Both flops reset to 1 because the divided clock idles high out of reset,
// so the first sample after release cannot look like a rising edge.
module tick_gen (
    input  logic pclk,
    input  logic presetn,
    input  logic clk_in,
    output logic tick
);
    logic s1_reg;
    logic s2_reg;

    // Sample the divided clock and keep one cycle of history.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            s1_reg <= 1'b1;
            s2_reg <= 1'b1;
        end else begin
            s1_reg <= clk_in;
            s2_reg <= s1_reg;
        end
    end

    assign tick = s1_reg & ~s2_reg;
endmodule

// File: rtl/timer_cnt.sv
// Loadable up/down timer counter advanced by rising edges of the selected
// divided clock, with sticky overflow/underflow flags.
module timer_cnt
    import timer_pkg::*;
#(
    parameter int WIDTH = TMR_WIDTH
) (
    input  logic        pclk,
    input  logic        presetn,
    timer_cnt_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    logic             tick;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic             udf_reg;
    logic             udf_next;

    tick_gen u_tick_gen (
        .pclk    (pclk),
        .presetn (presetn),
        .clk_in  (bus.clk_in),
        .tick    (tick)
    );

    // Next count and flags: load beats ticks, flag sets beat flag clears.
    always_comb begin
        cnt_next = cnt_reg;
        ovf_next = ovf_reg & ~bus.ovf_clr;
        udf_next = udf_reg & ~bus.udf_clr;
        if (bus.load) begin
            // A tick coinciding with a load is deliberately dropped.
            cnt_next = bus.tdr;
        end else if (bus.en && tick) begin
            case (bus.dir)
                DIR_UP: begin
                    cnt_next = cnt_reg + ONE;
                    if (cnt_reg == ALL_ONES) begin
                        ovf_next = 1'b1;
                    end
                end
                DIR_DOWN: begin
                    cnt_next = cnt_reg - ONE;
                    if (cnt_reg == ZERO) begin
                        udf_next = 1'b1;
                    end
                end
                default: cnt_next = cnt_reg;
            endcase
        end
    end

    // Count and flag registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_reg <= ZERO;
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
            udf_reg <= udf_next;
        end
    end

    assign bus.cnt  = cnt_reg;
    assign bus.ovf  = ovf_reg;
    assign bus.udf  = udf_reg;
    assign bus.tick = tick;
endmodule

// File: tb/tb_timer_cnt.sv
// Directed table-driven bench for timer_cnt. Each vector is applied just
// after a pclk edge and the outputs are compared 1 ns after the next edge.
module tb_timer_cnt;
    import timer_pkg::*;

    typedef struct {
        logic clk_in;
        logic en;
        logic dir;
        logic load;
        cnt_t tdr;
        logic ovf_clr;
        logic udf_clr;
        cnt_t exp_cnt;
        logic exp_ovf;
        logic exp_udf;
        logic exp_tick;
    } vec_t;

    logic pclk;
    logic presetn;
    int   n_cmp;
    int   n_bad;
    vec_t tbl[$];
    vec_t post[$];

    timer_cnt_if #(.WIDTH(TMR_WIDTH)) bus ();

    timer_cnt #(.WIDTH(TMR_WIDTH)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic add(ref vec_t q[$], input logic c, input logic e, input logic d,
                       input logic ld, input cnt_t t, input logic oc, input logic uc,
                       input cnt_t ec, input logic eo, input logic eu, input logic et);
        vec_t v;
        v.clk_in = c;  v.en = e;  v.dir = d;  v.load = ld;  v.tdr = t;
        v.ovf_clr = oc; v.udf_clr = uc;
        v.exp_cnt = ec; v.exp_ovf = eo; v.exp_udf = eu; v.exp_tick = et;
        q.push_back(v);
    endtask

    task automatic check(input string name, input cnt_t ec, input logic eo,
                         input logic eu, input logic et);
        n_cmp++;
        if (bus.cnt !== ec || bus.ovf !== eo || bus.udf !== eu || bus.tick !== et) begin
            n_bad++;
            $display("FAIL %s: got cnt=%h ovf=%b udf=%b tick=%b, want cnt=%h ovf=%b udf=%b tick=%b",
                     name, bus.cnt, bus.ovf, bus.udf, bus.tick, ec, eo, eu, et);
        end else begin
            $display("ok   %s: cnt=%h ovf=%b udf=%b tick=%b",
                     name, bus.cnt, bus.ovf, bus.udf, bus.tick);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        bus.clk_in  = v.clk_in;
        bus.en      = v.en;
        bus.dir     = v.dir;
        bus.load    = v.load;
        bus.tdr     = v.tdr;
        bus.ovf_clr = v.ovf_clr;
        bus.udf_clr = v.udf_clr;
        @(posedge pclk);
        #1;
        check(name, v.exp_cnt, v.exp_ovf, v.exp_udf, v.exp_tick);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // clk  en dir ld tdr    oc uc | cnt  ovf udf tick
        // Divide-by-2 counting up from reset: 5 rises -> 5
        add(tbl, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        add(tbl, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        add(tbl, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        add(tbl, 0, 1, 0, 0, 8'h00, 0, 0, 8'h01, 0, 0, 0);
        add(tbl, 1, 1, 0, 0, 8'h00, 0, 0, 8'h01, 0, 0, 1);
        add(tbl, 0, 1, 0, 0, 8'h00, 0, 0, 8'h02, 0, 0, 0);
        add(tbl, 1, 1, 0, 0, 8'h00, 0, 0, 8'h02, 0, 0, 1);
        add(tbl, 0, 1, 0, 0, 8'h00, 0, 0, 8'h03, 0, 0, 0);
        add(tbl, 1, 1, 0, 0, 8'h00, 0, 0, 8'h03, 0, 0, 1);
        add(tbl, 0, 1, 0, 0, 8'h00, 0, 0, 8'h04, 0, 0, 0);
        add(tbl, 1, 1, 0, 0, 8'h00, 0, 0, 8'h04, 0, 0, 1);
        add(tbl, 0, 1, 0, 0, 8'h00, 0, 0, 8'h05, 0, 0, 0);
        // Overflow FE -> FF -> 00, then clear
        add(tbl, 0, 1, 0, 1, 8'hFE, 0, 0, 8'hFE, 0, 0, 0);
        add(tbl, 1, 1, 0, 0, 8'h00, 0, 0, 8'hFE, 0, 0, 1);
        add(tbl, 0, 1, 0, 0, 8'h00, 0, 0, 8'hFF, 0, 0, 0);
        add(tbl, 1, 1, 0, 0, 8'h00, 0, 0, 8'hFF, 0, 0, 1);
        add(tbl, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
        add(tbl, 0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
        // Underflow 01 -> 00 -> FF; second underflow with a coincident clear
        add(tbl, 0, 1, 1, 1, 8'h01, 0, 0, 8'h01, 0, 0, 0);
        add(tbl, 1, 1, 1, 0, 8'h00, 0, 0, 8'h01, 0, 0, 1);
        add(tbl, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        add(tbl, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        add(tbl, 0, 1, 1, 0, 8'h00, 0, 0, 8'hFF, 0, 1, 0);
        add(tbl, 0, 1, 1, 1, 8'h00, 0, 0, 8'h00, 0, 1, 0);
        add(tbl, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1);
        add(tbl, 0, 1, 1, 0, 8'h00, 0, 1, 8'hFF, 0, 1, 0);
        add(tbl, 0, 1, 1, 0, 8'h00, 0, 1, 8'hFF, 0, 0, 0);
        // Load on the tick cycle wins; FF+1 must not happen, so no overflow
        add(tbl, 1, 1, 0, 0, 8'h00, 0, 0, 8'hFF, 0, 0, 1);
        add(tbl, 0, 1, 0, 1, 8'h40, 0, 0, 8'h40, 0, 0, 0);
        add(tbl, 1, 1, 0, 0, 8'h00, 0, 0, 8'h40, 0, 0, 1);
        add(tbl, 0, 1, 0, 0, 8'h00, 0, 0, 8'h41, 0, 0, 0);
        // Disabled for 3 periods, then exactly one step per rise
        add(tbl, 1, 0, 0, 0, 8'h00, 0, 0, 8'h41, 0, 0, 1);
        add(tbl, 0, 0, 0, 0, 8'h00, 0, 0, 8'h41, 0, 0, 0);
        add(tbl, 1, 0, 0, 0, 8'h00, 0, 0, 8'h41, 0, 0, 1);
        add(tbl, 0, 0, 0, 0, 8'h00, 0, 0, 8'h41, 0, 0, 0);
        add(tbl, 1, 0, 0, 0, 8'h00, 0, 0, 8'h41, 0, 0, 1);
        add(tbl, 0, 0, 0, 0, 8'h00, 0, 0, 8'h41, 0, 0, 0);
        add(tbl, 0, 1, 0, 0, 8'h00, 0, 0, 8'h41, 0, 0, 0);
        add(tbl, 1, 1, 0, 0, 8'h00, 0, 0, 8'h41, 0, 0, 1);
        add(tbl, 0, 1, 0, 0, 8'h00, 0, 0, 8'h42, 0, 0, 0);
        add(tbl, 1, 1, 0, 0, 8'h00, 0, 0, 8'h42, 0, 0, 1);
        add(tbl, 0, 1, 0, 0, 8'h00, 0, 0, 8'h43, 0, 0, 0);
        // Build cnt=33 with ovf=1 ahead of the reset test
        add(tbl, 0, 1, 0, 1, 8'hFF, 0, 0, 8'hFF, 0, 0, 0);
        add(tbl, 1, 1, 0, 0, 8'h00, 0, 0, 8'hFF, 0, 0, 1);
        add(tbl, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
        add(tbl, 0, 1, 0, 1, 8'h33, 0, 0, 8'h33, 1, 0, 0);
        // After the mid-count reset: no tick first cycle, then normal counting
        add(post, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        add(post, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        add(post, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        add(post, 0, 1, 0, 0, 8'h00, 0, 0, 8'h01, 0, 0, 0);

        // Reset with the divided clock idling high
        presetn     = 1'b0;
        bus.clk_in  = 1'b1;
        bus.en      = 1'b0;
        bus.dir     = DIR_UP;
        bus.load    = 1'b0;
        bus.tdr     = '0;
        bus.ovf_clr = 1'b0;
        bus.udf_clr = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
        presetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-cycle with cnt=33, ovf=1
        bus.clk_in = 1'b1;
        bus.load   = 1'b0;
        #2;
        presetn = 1'b0;
        #1;
        check("async_reset_immediate", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge pclk);
        #1;
        check("reset_held", 8'h00, 1'b0, 1'b0, 1'b0);
        presetn = 1'b1;

        for (int i = 0; i < post.size(); i++) begin
            apply(post[i], $sformatf("post_reset%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
